// File: rtl/mac_accumulator.sv
// Accumulate stage: sums LEN signed products with saturation and hands
// each finished result downstream over a valid/ready handshake.
module mac_accumulator #(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 24,
    parameter int LEN       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_overflow
);

    localparam int CW  = $clog2(LEN) + 1;
    localparam int EXT = ACC_WIDTH + 1 - IN_WIDTH;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_ovf_q, out_ovf_d;

    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH-1:0] sat;
    logic                 clamp;
    logic                 accept;
    logic                 last;

    assign in_ready     = (state_q == ACCUM);
    assign out_valid    = (state_q == HOLD);
    assign out_data     = out_data_q;
    assign out_overflow = out_ovf_q;

    assign accept = in_valid & in_ready;
    assign last   = (cnt_q == CW'(LEN - 1));

    // One guard bit: the top two sum bits disagree exactly on overflow.
    always_comb begin
        sum   = {{EXT{in_data[IN_WIDTH-1]}}, in_data}
              + {acc_q[ACC_WIDTH-1], acc_q};
        sat   = sum[ACC_WIDTH-1:0];
        clamp = 1'b0;
        if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
            clamp = 1'b1;
            sat   = {sum[ACC_WIDTH], {(ACC_WIDTH-1){~sum[ACC_WIDTH]}}};
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        if (clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (accept) begin
                        if (last) begin
                            out_data_d = sat;
                            out_ovf_d  = ovf_q | clamp;
                            state_d    = HOLD;
                        end else begin
                            acc_d = sat;
                            cnt_d = cnt_q + CW'(1);
                            ovf_d = ovf_q | clamp;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench: a 24-bit and a 16-bit accumulator (LEN=4) share
// the same stimulus; each is checked against hand-computed sums.
module tb_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_ovf;
    logic [23:0] a_data;
    logic        b_in_ready, b_out_valid, b_ovf;
    logic [15:0] b_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mac_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(24), .LEN(4)) dut_a (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_data), .out_overflow(a_ovf)
    );

    mac_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(16), .LEN(4)) dut_b (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_data), .out_overflow(b_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int v);
        in_valid = 1'b1;
        in_data  = 16'(v);
        step();
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sa(input logic [23:0] v);
        return int'($signed(v));
    endfunction

    function automatic int sb(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_out_valid", int'(a_out_valid), 0);
        chk("rst_in_ready", int'(a_in_ready), 1);
        chk("rst_out_data", sa(a_data), 0);
        chk("rst_ovf", int'(a_ovf), 0);
        chk("rst_b_in_ready", int'(b_in_ready), 1);

        // basic sum
        out_ready = 1'b1;
        feed(10); feed(-3); feed(7); feed(100);
        in_valid = 1'b0;
        chk("basic_valid", int'(a_out_valid), 1);
        chk("basic_data", sa(a_data), 114);
        chk("basic_ovf", int'(a_ovf), 0);
        chk("basic_in_ready_hold", int'(a_in_ready), 0);
        step();
        chk("basic_valid_drop", int'(a_out_valid), 0);
        chk("basic_in_ready", int'(a_in_ready), 1);

        // backpressure with gaps; a product offered in HOLD is ignored
        out_ready = 1'b0;
        feed(1); in_valid = 1'b0; step();
        feed(2); in_valid = 1'b0; step();
        feed(3); in_valid = 1'b0; step();
        feed(4);
        in_data = 16'd99;
        for (int i = 0; i < 5; i++) begin
            chk("bp_data", sa(a_data), 10);
            chk("bp_in_ready", int'(a_in_ready), 0);
            chk("bp_valid", int'(a_out_valid), 1);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", int'(a_out_valid), 0);
        chk("bp_release_in_ready", int'(a_in_ready), 1);
        feed(1); feed(1); feed(1); feed(1);
        in_valid = 1'b0;
        chk("bp_fresh_data", sa(a_data), 4);
        step();

        // positive saturation (16-bit instance)
        rst = 1'b1; step(); rst = 1'b0;
        feed(32767); feed(1); feed(-5); feed(0);
        in_valid = 1'b0;
        chk("psat_b_data", sb(b_data), 32762);
        chk("psat_b_ovf", int'(b_ovf), 1);
        chk("psat_a_data", sa(a_data), 32763);
        chk("psat_a_ovf", int'(a_ovf), 0);
        step();
        feed(1); feed(1); feed(1); feed(1);
        in_valid = 1'b0;
        chk("psat_next_data", sb(b_data), 4);
        chk("psat_next_ovf", int'(b_ovf), 0);
        step();

        // negative saturation
        feed(-32768); feed(-1); feed(0); feed(0);
        in_valid = 1'b0;
        chk("nsat_b_data", sb(b_data), -32768);
        chk("nsat_b_ovf", int'(b_ovf), 1);
        chk("nsat_a_data", sa(a_data), -32769);
        chk("nsat_a_ovf", int'(a_ovf), 0);
        step();

        // clear mid-sum, then rst during HOLD
        out_ready = 1'b0;
        feed(7); feed(7);
        in_valid = 1'b0;
        clear = 1'b1; step(); clear = 1'b0;
        feed(5); feed(5); feed(5); feed(5);
        in_valid = 1'b0;
        chk("clr_data", sa(a_data), 20);
        chk("clr_valid", int'(a_out_valid), 1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_hold_valid", int'(a_out_valid), 0);
        chk("rst_hold_in_ready", int'(a_in_ready), 1);
        chk("rst_hold_data", sa(a_data), 0);

        // clear drops a same-cycle product
        in_valid = 1'b1; in_data = 16'd50;
        clear = 1'b1; step(); clear = 1'b0;
        in_valid = 1'b0;
        feed(1); feed(2); feed(3);
        in_valid = 1'b0;
        chk("clr_drop_not_done", int'(a_out_valid), 0);
        feed(4);
        in_valid = 1'b0;
        chk("clr_drop_data", sa(a_data), 10);
        chk("clr_drop_valid", int'(a_out_valid), 1);

        // clear beats out_ready in HOLD; out_data is kept
        out_ready = 1'b1;
        clear = 1'b1; step(); clear = 1'b0;
        chk("clr_hold_valid", int'(a_out_valid), 0);
        chk("clr_hold_in_ready", int'(a_in_ready), 1);
        chk("clr_hold_data", sa(a_data), 10);
        feed(2); feed(2); feed(2); feed(2);
        in_valid = 1'b0;
        chk("clr_hold_next", sa(a_data), 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
